// File: rtl/noc_writer_pkg.sv
// Shared NoC definitions: flit field positions, writer FSM states and VC-width helper.
package noc_writer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } wr_state_e;

  // A single-VC link still carries a one-bit VC field so the slice is never empty.
  function automatic int vc_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  function automatic int valid_pos(input int width);
    return width - 1;
  endfunction

  function automatic int head_pos(input int width);
    return width - 2;
  endfunction

  function automatic int tail_pos(input int width);
    return width - 3;
  endfunction

  function automatic int vc_msb(input int width);
    return width - 4;
  endfunction

endpackage

// File: rtl/noc_writer_if.sv
// Writer-side bundle: show-ahead afifo read port plus the NoC link flit/credit wires.
interface noc_writer_if #(
  parameter int WIDTH  = 36,
  parameter int NUM_VC = 2
);
  logic [WIDTH-1:0]  i_data_in;
  logic              i_empty_in;
  logic              i_read_en;
  logic [WIDTH-1:0]  o_flit_out;
  logic [NUM_VC-1:0] o_credits_in;

  modport master (
    input  i_data_in, i_empty_in, o_credits_in,
    output i_read_en, o_flit_out
  );

  modport slave (
    output i_data_in, i_empty_in, o_credits_in,
    input  i_read_en, o_flit_out
  );
endinterface

// File: rtl/noc_writer_credit_counter.sv
// Per-VC credit counter: starts full, -1 per flit sent, +1 per credit pulse, saturating.
module credit_counter #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CW'(DEPTH);
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end else if (inc && !dec && count != CW'(DEPTH)) begin
      count <= count + 1'b1;
    end
  end

  // Downstream returned a credit it never consumed: protocol error upstream.
  credit_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inc && !dec && count == CW'(DEPTH)));

endmodule

// File: rtl/noc_writer.sv
// NoC writer: pops packets from an afifo, allocates a VC round-robin per packet and
// emits registered flits while tracking downstream credits per VC.
module noc_writer
  import noc_writer_pkg::*;
#(
  parameter int WIDTH        = 36,
  parameter int NUM_VC       = 2,
  parameter int DEPTH_PER_VC = 8,
  parameter int N            = 16
) (
  input logic        clk,
  input logic        rst,
  noc_writer_if.master bus
);

  localparam int VCW     = vc_width(NUM_VC);
  localparam int CW      = $clog2(DEPTH_PER_VC + 1);
  localparam int P_VALID = valid_pos(WIDTH);
  localparam int P_HEAD  = head_pos(WIDTH);
  localparam int P_TAIL  = tail_pos(WIDTH);
  localparam int P_VC    = vc_msb(WIDTH);

  if (N < 1 || NUM_VC < 1 || DEPTH_PER_VC < 1 || WIDTH < 4 + VCW) begin : g_param_check
    $error("noc_writer: illegal parameter combination");
  end

  wr_state_e         state, next_state;
  logic [VCW-1:0]    cur_vc, last_vc, sel_vc, pop_vc;
  logic              sel_found, alloc, emit, read_en;
  logic [NUM_VC-1:0] has_credit, dec;
  logic [CW-1:0]     credit [NUM_VC];
  logic [WIDTH-1:0]  flit_next, flit;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign dec[v]        = emit && (pop_vc == VCW'(v));
    assign has_credit[v] = (credit[v] != '0);

    credit_counter #(.DEPTH(DEPTH_PER_VC), .CW(CW)) u_credit (
      .clk   (clk),
      .rst   (rst),
      .dec   (dec[v]),
      .inc   (bus.o_credits_in[v]),
      .count (credit[v])
    );
  end

  // Descending scan so the nearest VC after last_vc is the one left standing.
  always_comb begin
    sel_vc    = '0;
    sel_found = 1'b0;
    for (int k = NUM_VC; k >= 1; k--) begin
      if (has_credit[(int'(last_vc) + k) % NUM_VC]) begin
        sel_vc    = VCW'((int'(last_vc) + k) % NUM_VC);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    read_en    = 1'b0;
    alloc      = 1'b0;
    emit       = 1'b0;
    pop_vc     = cur_vc;
    if (!rst && !bus.i_empty_in) begin
      unique case (state)
        IDLE: begin
          if (!bus.i_data_in[P_VALID] || !bus.i_data_in[P_HEAD]) begin
            read_en = 1'b1;
          end else if (sel_found) begin
            read_en = 1'b1;
            emit    = 1'b1;
            alloc   = 1'b1;
            pop_vc  = sel_vc;
            if (!bus.i_data_in[P_TAIL]) next_state = SEND;
          end
        end
        SEND: begin
          if (has_credit[cur_vc]) begin
            read_en = 1'b1;
            emit    = 1'b1;
            if (bus.i_data_in[P_TAIL]) next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    flit_next                   = bus.i_data_in;
    flit_next[P_VALID]          = 1'b1;
    flit_next[P_VC -: VCW]      = pop_vc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur_vc  <= '0;
      last_vc <= VCW'(NUM_VC - 1);
      flit    <= '0;
    end else begin
      state <= next_state;
      if (alloc) begin
        cur_vc  <= sel_vc;
        last_vc <= sel_vc;
      end
      flit <= emit ? flit_next : '0;
    end
  end

  assign bus.i_read_en  = read_en;
  assign bus.o_flit_out = flit;

endmodule

// File: tb/tb_noc_writer.sv
// Scoreboard bench for noc_writer: packet-level reference model predicts pops and flits,
// a separate monitor compares every link cycle against the expected-flit queue.
module tb_noc_writer;

  localparam int W   = 36;
  localparam int NV  = 2;
  localparam int D   = 8;
  localparam int VCW = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_writer_if #(.WIDTH(W), .NUM_VC(NV)) bus ();

  noc_writer #(.WIDTH(W), .NUM_VC(NV), .DEPTH_PER_VC(D), .N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] fifo [$];
  logic [W-1:0] expq [$];
  bit pend_pop = 1'b0;
  bit mon_en   = 1'b0;

  int m_open;
  int m_last;
  int m_credit [NV];

  task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_open = -1;
    m_last = NV - 1;
    for (int c = 0; c < NV; c++) m_credit[c] = D;
  endtask

  function automatic logic [W-1:0] mk(input bit v, input bit h, input bit t);
    logic [63:0]  r;
    logic [W-1:0] w;
    r = {$urandom, $urandom};
    w = r[W-1:0];
    w[W-1] = v;
    w[W-2] = h;
    w[W-3] = t;
    return w;
  endfunction

  task automatic push_pkt(input int n);
    for (int i = 0; i < n; i++) fifo.push_back(mk(1'b1, i == 0, i == n - 1));
  endtask

  function automatic logic [NV-1:0] cred_on(input int c);
    logic [NV-1:0] m;
    m = '0;
    if (m_credit[c] < D) m[c] = 1'b1;
    return m;
  endfunction

  function automatic logic [NV-1:0] rand_cred(input int pct);
    logic [NV-1:0] m;
    m = '0;
    for (int c = 0; c < NV; c++)
      if (m_credit[c] < D && $urandom_range(99) < pct) m[c] = 1'b1;
    return m;
  endfunction

  // One link cycle: drive afifo front and credit pulses, predict the pop, queue the flit.
  task automatic applyStimulus(input logic [NV-1:0] cred, input bit do_rst);
    bit pop, emit, v, h, t;
    int vc;
    logic [W-1:0] w, f;
    @(negedge clk);
    if (pend_pop && fifo.size() > 0) void'(fifo.pop_front());
    bus.i_empty_in   = (fifo.size() == 0);
    bus.i_data_in    = (fifo.size() > 0) ? fifo[0] : '0;
    bus.o_credits_in = cred;
    #1 rst = do_rst;
    #1;
    pop  = 1'b0;
    emit = 1'b0;
    vc   = 0;
    w    = bus.i_data_in;
    if (do_rst) begin
      if (mon_en) checkOutput("pending_at_reset", W'(expq.size()), '0);
      expq.delete();
      model_reset();
    end else begin
      if (fifo.size() > 0) begin
        v = w[W-1];
        h = w[W-2];
        t = w[W-3];
        if (m_open < 0) begin
          if (!v || !h) begin
            pop = 1'b1;
          end else begin
            for (int k = 1; k <= NV; k++) begin
              if (!emit && m_credit[(m_last + k) % NV] > 0) begin
                emit = 1'b1;
                vc   = (m_last + k) % NV;
              end
            end
            if (emit) begin
              pop    = 1'b1;
              m_last = vc;
              if (!t) m_open = vc;
            end
          end
        end else if (m_credit[m_open] > 0) begin
          pop  = 1'b1;
          emit = 1'b1;
          vc   = m_open;
          if (t) m_open = -1;
        end
      end
      for (int c = 0; c < NV; c++)
        m_credit[c] += int'(cred[c]) - ((emit && vc == c) ? 1 : 0);
    end
    checkOutput("read_en", W'(bus.i_read_en), W'(pop));
    if (emit) begin
      f = w;
      f[W-1] = 1'b1;
      f[W-4 -: VCW] = VCW'(vc);
      expq.push_back(f);
    end
    pend_pop = bus.i_read_en;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_flit_out[W-1]) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL flit_unexpected: got %h expected no flit at %0t", bus.o_flit_out, $time);
        end else begin
          checkOutput("flit", bus.o_flit_out, expq.pop_front());
        end
      end else begin
        checkOutput("idle_zero", bus.o_flit_out, '0);
      end
    end
  end

  initial begin
    rst              = 1'b1;
    bus.i_empty_in   = 1'b1;
    bus.i_data_in    = '0;
    bus.o_credits_in = '0;
    model_reset();
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    mon_en = 1'b1;
    applyStimulus('0, 1'b1);

    $display("[TB] single 4-flit packet");
    push_pkt(4);
    repeat (8) applyStimulus('0, 1'b0);
    repeat (4) applyStimulus(cred_on(0), 1'b0);

    $display("[TB] nine single-flit packets, then drain and one VC1 credit");
    applyStimulus('0, 1'b1);
    repeat (9) push_pkt(1);
    repeat (12) applyStimulus('0, 1'b0);
    repeat (8) push_pkt(1);
    repeat (12) applyStimulus('0, 1'b0);
    applyStimulus(cred_on(1), 1'b0);
    repeat (4) applyStimulus('0, 1'b0);

    $display("[TB] mid-packet credit stall on VC0");
    applyStimulus('0, 1'b1);
    push_pkt(12);
    push_pkt(1);
    repeat (14) applyStimulus('0, 1'b0);
    repeat (6) begin
      applyStimulus(cred_on(0), 1'b0);
      applyStimulus('0, 1'b0);
    end
    repeat (20) applyStimulus(rand_cred(40), 1'b0);

    $display("[TB] reset in the middle of a packet");
    applyStimulus('0, 1'b1);
    fifo.delete();
    pend_pop = 1'b0;
    applyStimulus('0, 1'b0);
    push_pkt(4);
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    push_pkt(2);
    repeat (8) applyStimulus('0, 1'b0);

    $display("[TB] randomized traffic");
    repeat (800) begin
      if (fifo.size() < 8 && $urandom_range(3) == 0) begin
        if ($urandom_range(4) == 0) begin
          bit gv;
          gv = 1'($urandom_range(1));
          fifo.push_back(mk(gv, gv ? 1'b0 : 1'($urandom_range(1)), 1'($urandom_range(1))));
        end else begin
          push_pkt($urandom_range(5, 1));
        end
      end
      applyStimulus(rand_cred(30), 1'b0);
    end
    repeat (80) applyStimulus(rand_cred(50), 1'b0);
    @(negedge clk);
    #3;
    checkOutput("leftover_expected", W'(expq.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
